// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver FSM encoding, default line constants used by the
// in-house 8N1 sender, and the oversample divisor calculation.
package uart_receiver_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_e;

   localparam int unsigned UART_CLK_FREQ = 32'd100_000_000;
   localparam int unsigned UART_BAUD     = 32'd9600;

   // Rounded sysclks per oversample tick, never below one.
   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned baud,
                                            input int unsigned oversample);
      int unsigned den;
      int unsigned quo;
      den = baud * oversample;
      quo = (clk_freq + (den / 32'd2)) / den;
      if (quo < 32'd1) begin
         return 32'd1;
      end else begin
         return quo;
      end
   endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV sysclks, restartable so the
// tick phase is fixed relative to the detected start edge.
module uart_rx_tick_gen #(
   parameter int unsigned DIV = 32'd4
) (
   input  logic sysclk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2(DIV + 32'd1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 32'd1);

   logic [CNT_W-1:0] cnt_r;
   logic             tick_r;

   // Divider counter with registered tick on wrap.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         cnt_r  <= {CNT_W{1'b0}};
         tick_r <= 1'b0;
      end else if (clear) begin
         cnt_r  <= {CNT_W{1'b0}};
         tick_r <= 1'b0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r  <= {CNT_W{1'b0}};
         tick_r <= 1'b1;
      end else begin
         cnt_r  <= cnt_r + CNT_W'(1);
         tick_r <= 1'b0;
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: synchronises the line, oversamples each bit at mid-point and
// presents each byte with a one-cycle RX_STATUS pulse (RX_ERROR on a bad stop bit).
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = UART_CLK_FREQ,
   parameter int unsigned BAUD        = UART_BAUD,
   parameter int unsigned OVERSAMPLE  = 32'd16,
   parameter int unsigned INVERT_DATA = 32'd1
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       UART_RX,
   output logic [7:0] RX_DATA,
   output logic       RX_STATUS,
   output logic       RX_ERROR,
   output logic       busy
);

   localparam int unsigned DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
   localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 32'd2 - 32'd1);
   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 32'd1);
   localparam logic INV_BIT = (INVERT_DATA != 32'd0) ? 1'b1 : 1'b0;

   logic              sync1_r, sync2_r;
   logic [1:0]        fill_r;
   logic              armed_r;
   logic              rx_s;
   logic              tick_s, tick_clear_s;
   rx_state_e         state_r, state_s;
   logic [SCNT_W-1:0] scnt_r, scnt_s;
   logic [2:0]        bit_r, bit_s;
   logic [7:0]        shift_r, shift_s;
   logic [7:0]        data_r, data_s;
   logic              status_r, status_s;
   logic              error_r, error_s;
   logic              busy_r;

   assign rx_s = sync2_r;

   // Two-flop synchroniser; armed only once a real high level has been seen after
   // reset, so a line held low out of reset never looks like a start bit.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         fill_r  <= 2'b00;
         armed_r <= 1'b0;
      end else begin
         sync1_r <= UART_RX;
         sync2_r <= sync1_r;
         fill_r  <= {fill_r[0], 1'b1};
         armed_r <= armed_r | (fill_r[1] & sync2_r);
      end
   end

   uart_rx_tick_gen #(.DIV(DIV)) u_tick (
      .sysclk (sysclk),
      .reset  (reset),
      .clear  (tick_clear_s),
      .tick   (tick_s)
   );

   // Next-state and datapath decisions.
   always_comb begin
      state_s      = state_r;
      scnt_s       = scnt_r;
      bit_s        = bit_r;
      shift_s      = shift_r;
      data_s       = data_r;
      status_s     = 1'b0;
      error_s      = 1'b0;
      tick_clear_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // Every path into IDLE leaves the line high, so low here is a fresh edge.
            if (armed_r && !rx_s) begin
               state_s      = ST_START;
               scnt_s       = {SCNT_W{1'b0}};
               tick_clear_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s) begin
               if (scnt_r == SCNT_HALF) begin
                  scnt_s = {SCNT_W{1'b0}};
                  bit_s  = 3'd0;
                  if (!rx_s) begin
                     state_s = ST_DATA;
                  end else begin
                     state_s = ST_IDLE;
                  end
               end else begin
                  scnt_s = scnt_r + SCNT_W'(1);
               end
            end else begin
               state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               if (scnt_r == SCNT_LAST) begin
                  scnt_s  = {SCNT_W{1'b0}};
                  shift_s = {rx_s ^ INV_BIT, shift_r[7:1]};
                  bit_s   = bit_r + 3'd1;
                  if (bit_r == 3'd7) begin
                     state_s = ST_STOP;
                  end else begin
                     state_s = ST_DATA;
                  end
               end else begin
                  scnt_s = scnt_r + SCNT_W'(1);
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_STOP: begin
            if (tick_s) begin
               if (scnt_r == SCNT_LAST) begin
                  scnt_s = {SCNT_W{1'b0}};
                  if (rx_s) begin
                     data_s   = shift_r;
                     status_s = 1'b1;
                     state_s  = ST_IDLE;
                  end else begin
                     error_s = 1'b1;
                     state_s = ST_BREAK;
                  end
               end else begin
                  scnt_s = scnt_r + SCNT_W'(1);
               end
            end else begin
               state_s = ST_STOP;
            end
         end
         ST_BREAK: begin
            if (rx_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_BREAK;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM, shift register and registered outputs.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_r  <= ST_IDLE;
         scnt_r   <= {SCNT_W{1'b0}};
         bit_r    <= 3'd0;
         shift_r  <= 8'h00;
         data_r   <= 8'h00;
         status_r <= 1'b0;
         error_r  <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         scnt_r   <= scnt_s;
         bit_r    <= bit_s;
         shift_r  <= shift_s;
         data_r   <= data_s;
         status_r <= status_s;
         error_r  <= error_s;
         busy_r   <= (state_s != ST_IDLE);
      end
   end

   assign RX_DATA   = data_r;
   assign RX_STATUS = status_r;
   assign RX_ERROR  = error_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised scoreboard bench for uart_receiver: a line-level sender queues the
// expected byte/error for each frame, independent monitors compare on every pulse.
module tb_uart_receiver;

   localparam int unsigned BAUD     = 32'd9600;
   localparam int unsigned CLK_FREQ = 32'd64 * BAUD;
   localparam int BIT_CLKS = 64;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b0;
   logic       rx_line  = 1'b1;
   logic       rx_plain = 1'b1;
   logic [7:0] rx_data, rx_data_p;
   logic       rx_status, rx_status_p;
   logic       rx_error, rx_error_p;
   logic       busy, busy_p;

   int         checks = 0;
   int         errors = 0;
   exp_t       exp_q[$];
   logic [7:0] plain_q[$];
   logic [7:0] last_good = 8'h00;
   exp_t       got_e;
   logic       pulse_prev = 1'b0;
   logic       pulse_prev_p = 1'b0;

   always #5 sysclk = ~sysclk;

   uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(32'd16), .INVERT_DATA(32'd1)) dut (
      .sysclk(sysclk), .reset(reset), .UART_RX(rx_line),
      .RX_DATA(rx_data), .RX_STATUS(rx_status), .RX_ERROR(rx_error), .busy(busy)
   );

   uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(32'd16), .INVERT_DATA(32'd0)) dut_plain (
      .sysclk(sysclk), .reset(reset), .UART_RX(rx_plain),
      .RX_DATA(rx_data_p), .RX_STATUS(rx_status_p), .RX_ERROR(rx_error_p), .busy(busy_p)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor for the inverted-data receiver.
   always @(negedge sysclk) begin
      if (reset) begin
         if (rx_status || rx_error) begin
            checks++;
            if (rx_status && rx_error) begin
               errors++;
               $display("FAIL both_pulses status=%b error=%b", rx_status, rx_error);
            end else if (pulse_prev) begin
               errors++;
               $display("FAIL pulse_width pulse held for more than one cycle");
            end else if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse status=%b error=%b data=%h", rx_status, rx_error, rx_data);
            end else begin
               got_e = exp_q.pop_front();
               if (got_e.err !== rx_error || got_e.data !== rx_data) begin
                  errors++;
                  $display("FAIL frame actual err=%b data=%h required err=%b data=%h",
                           rx_error, rx_data, got_e.err, got_e.data);
               end
            end
         end
         pulse_prev = rx_status | rx_error;
      end else begin
         pulse_prev = 1'b0;
      end
   end

   // Monitor for the plain-data receiver.
   always @(negedge sysclk) begin
      if (reset) begin
         if (rx_status_p || rx_error_p) begin
            checks++;
            if (rx_error_p || pulse_prev_p || plain_q.size() == 0) begin
               errors++;
               $display("FAIL plain_pulse status=%b error=%b data=%h", rx_status_p, rx_error_p, rx_data_p);
            end else if (plain_q[0] !== rx_data_p) begin
               errors++;
               $display("FAIL plain_data actual=%h required=%h", rx_data_p, plain_q[0]);
               void'(plain_q.pop_front());
            end else begin
               void'(plain_q.pop_front());
            end
         end
         pulse_prev_p = rx_status_p | rx_error_p;
      end else begin
         pulse_prev_p = 1'b0;
      end
   end

   task automatic drive_bit(input logic v);
      rx_line = v;
      repeat (BIT_CLKS) @(posedge sysclk);
   endtask

   // Sender convention: data bits inverted on the line, start/stop not.
   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(~b[i]);
      drive_bit(stop_v);
      rx_line = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] b);
      exp_q.push_back({1'b0, b});
      last_good = b;
      send_frame(b, 1'b1);
   endtask

   task automatic send_plain(input logic [7:0] b);
      plain_q.push_back(b);
      rx_plain = 1'b0;
      repeat (BIT_CLKS) @(posedge sysclk);
      for (int i = 0; i < 8; i++) begin
         rx_plain = b[i];
         repeat (BIT_CLKS) @(posedge sysclk);
      end
      rx_plain = 1'b1;
      repeat (BIT_CLKS) @(posedge sysclk);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 2000 && (exp_q.size() != 0 || plain_q.size() != 0); i++)
         @(posedge sysclk);
      check(name, 32'(exp_q.size() + plain_q.size()), 32'd0);
      exp_q.delete();
      plain_q.delete();
   endtask

   initial begin
      logic seen;
      logic [7:0] rb;

      // Reset state and quiet idle line.
      repeat (5) @(posedge sysclk);
      @(negedge sysclk);
      check("reset_data", 32'(rx_data), 32'h00);
      check("reset_status", 32'(rx_status), 32'h0);
      check("reset_error", 32'(rx_error), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      reset = 1'b1;
      repeat (20 * BIT_CLKS) @(posedge sysclk);
      @(negedge sysclk);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_data", 32'(rx_data), 32'h00);

      // Single frames, both data polarities.
      send_good(8'hA5);
      send_plain(8'hA5);
      drain("drain_a5");
      check("a5_data", 32'(rx_data), 32'hA5);
      check("a5_plain_data", 32'(rx_data_p), 32'hA5);

      // Back-to-back frames with single stop bits.
      send_good(8'h00);
      send_good(8'hFF);
      send_good(8'h3C);
      drain("drain_b2b");

      // Short low glitch: false start.
      repeat (BIT_CLKS) @(posedge sysclk);
      seen = 1'b0;
      @(negedge sysclk);
      rx_line = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge sysclk);
         if (busy) seen = 1'b1;
      end
      rx_line = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge sysclk);
         if (busy) seen = 1'b1;
      end
      check("glitch_busy_seen", 32'(seen), 32'h1);
      for (int i = 0; i < 200 && busy; i++) @(negedge sysclk);
      check("glitch_busy_clear", 32'(busy), 32'h0);
      repeat (2 * BIT_CLKS) @(posedge sysclk);
      check("glitch_data", 32'(rx_data), 32'h3C);

      // Framing error, line held low, then a good frame.
      exp_q.push_back({1'b1, last_good});
      send_frame(8'h55, 1'b0);
      rx_line = 1'b0;
      repeat (2 * BIT_CLKS) @(posedge sysclk);
      @(negedge sysclk);
      check("break_busy", 32'(busy), 32'h1);
      rx_line = 1'b1;
      repeat (BIT_CLKS) @(posedge sysclk);
      send_good(8'h96);
      drain("drain_framing");

      // Reset mid-frame with the line left low through release.
      rx_line = 1'b0;
      repeat (BIT_CLKS) @(posedge sysclk);
      for (int i = 0; i < 4; i++) drive_bit(~(8'hC3 >> i) & 8'h01 ? 1'b1 : 1'b0);
      repeat (10) @(posedge sysclk);
      reset = 1'b0;
      rx_line = 1'b0;
      last_good = 8'h00;
      @(negedge sysclk);
      check("midreset_data", 32'(rx_data), 32'h00);
      check("midreset_busy", 32'(busy), 32'h0);
      repeat (5) @(posedge sysclk);
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 3 * BIT_CLKS; i++) begin
         @(negedge sysclk);
         if (busy) seen = 1'b1;
      end
      check("held_low_no_start", 32'(seen), 32'h0);
      rx_line = 1'b1;
      repeat (2 * BIT_CLKS) @(posedge sysclk);
      send_good(8'h81);
      drain("drain_reset");
      check("after_reset_data", 32'(rx_data), 32'h81);

      // Random bytes with random inter-frame gaps.
      for (int n = 0; n < 8; n++) begin
         rb = 8'($urandom);
         send_good(rb);
         repeat ($urandom_range(0, 40)) @(posedge sysclk);
      end
      drain("drain_random");
      check("random_last", 32'(rx_data), 32'(last_good));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
